// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I$ fill path and the
// D$ miss/evict path. One-cycle request pulses are captured into per-requester
// pending slots, granted round-robin, and exactly one memory transaction is
// kept outstanding. The response is routed back combinationally to the
// granted requester. A watchdog reissues a transaction that gets no response.
//
// Ports:
//   clock, reset              system clock (rising edge), async active-low reset
//   icache_req_*              I$ fill request pulse + line address
//   icache_rsp_*              I$ response pulse + fill data
//   dcache_req_*              D$ request pulse, address, store flag, evict data
//   dcache_rsp_*              D$ response pulse (fill data or write ACK)
//   mem_req_*                 memory request pulse, address, write flag, data
//   mem_rsp_*                 memory response pulse + read data
//   busy                      a transaction is outstanding
//   protocol_error            one-cycle flag for an illegal handshake (registered)
//   timeout_error             one-cycle flag when the watchdog expires
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no transaction outstanding; issues a request if a slot is pending
// WAIT_RSP | request issued; waiting for mem_rsp_valid or watchdog expiry

module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  icache_req_valid,
   input  logic [ADDR_WIDTH-1:0] icache_req_addr,
   output logic                  icache_rsp_valid,
   output logic [LINE_WIDTH-1:0] icache_rsp_data,
   input  logic                  dcache_req_valid,
   input  logic [ADDR_WIDTH-1:0] dcache_req_addr,
   input  logic                  dcache_req_is_store,
   input  logic [LINE_WIDTH-1:0] dcache_req_data,
   output logic                  dcache_rsp_valid,
   output logic [LINE_WIDTH-1:0] dcache_rsp_data,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic                  mem_req_is_store,
   output logic [LINE_WIDTH-1:0] mem_req_data,
   input  logic                  mem_rsp_valid,
   input  logic [LINE_WIDTH-1:0] mem_rsp_data,
   output logic                  busy,
   output logic                  protocol_error,
   output logic                  timeout_error
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   localparam int              WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t                state, next_state;
   logic                  grant_id, next_grant, last_grant;
   logic [WD_W-1:0]       watchdog;

   logic                  i_pend;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  d_pend;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic                  d_store;
   logic [LINE_WIDTH-1:0] d_data;

   logic                  i_done, d_done;
   logic                  rsp_in_idle;
   logic                  i_dup, d_dup;

   // FSM state register, grant bookkeeping and watchdog
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_id   <= GNT_I;
         last_grant <= GNT_D;
         watchdog   <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && mem_req_valid) begin
            grant_id   <= next_grant;
            last_grant <= next_grant;
         end
         if (state == WAIT_RSP && next_state == WAIT_RSP)
            watchdog <= watchdog + 1'b1;
         else
            watchdog <= '0;
      end
   end

   always_comb begin
      next_state       = state;
      next_grant       = grant_id;
      i_done           = 1'b0;
      d_done           = 1'b0;
      rsp_in_idle      = 1'b0;
      mem_req_valid    = 1'b0;
      mem_req_addr     = '0;
      mem_req_is_store = 1'b0;
      mem_req_data     = '0;
      icache_rsp_valid = 1'b0;
      icache_rsp_data  = '0;
      dcache_rsp_valid = 1'b0;
      dcache_rsp_data  = '0;
      timeout_error    = 1'b0;

      case (state)
         IDLE: begin
            rsp_in_idle = mem_rsp_valid;
            if (i_pend || d_pend) begin
               mem_req_valid = 1'b1;
               if (i_pend && d_pend)
                  next_grant = ~last_grant;
               else
                  next_grant = d_pend ? GNT_D : GNT_I;
               if (next_grant == GNT_D) begin
                  mem_req_addr     = d_addr;
                  mem_req_is_store = d_store;
                  mem_req_data     = d_data;
               end else begin
                  mem_req_addr = i_addr;
               end
               next_state = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (mem_rsp_valid) begin
               if (grant_id == GNT_D) begin
                  dcache_rsp_valid = 1'b1;
                  dcache_rsp_data  = mem_rsp_data;
                  d_done           = 1'b1;
               end else begin
                  icache_rsp_valid = 1'b1;
                  icache_rsp_data  = mem_rsp_data;
                  i_done           = 1'b1;
               end
               next_state = IDLE;
            end else if (watchdog == WD_LAST) begin
               // slot stays pending so the request is re-arbitrated
               timeout_error = 1'b1;
               next_state    = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state == WAIT_RSP);

   // A request into an occupied slot is only legal when that slot's
   // response is delivered in the same cycle; then the new request reloads it.
   assign i_dup = icache_req_valid && i_pend && !i_done;
   assign d_dup = dcache_req_valid && d_pend && !d_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         i_pend         <= 1'b0;
         i_addr         <= '0;
         d_pend         <= 1'b0;
         d_addr         <= '0;
         d_store        <= 1'b0;
         d_data         <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (i_done)
            i_pend <= 1'b0;
         if (icache_req_valid && (!i_pend || i_done)) begin
            i_pend <= 1'b1;
            i_addr <= icache_req_addr;
         end
         if (d_done)
            d_pend <= 1'b0;
         if (dcache_req_valid && (!d_pend || d_done)) begin
            d_pend  <= 1'b1;
            d_addr  <= dcache_req_addr;
            d_store <= dcache_req_is_store;
            d_data  <= dcache_req_data;
         end
         protocol_error <= i_dup || d_dup || rsp_in_idle;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter. Stimulus pushes hand-computed
// expected events (with the cycle they must appear in) into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents a pulse.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;
   localparam int TO = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          icache_req_valid = 1'b0;
   logic [AW-1:0] icache_req_addr = '0;
   logic          icache_rsp_valid;
   logic [LW-1:0] icache_rsp_data;
   logic          dcache_req_valid = 1'b0;
   logic [AW-1:0] dcache_req_addr = '0;
   logic          dcache_req_is_store = 1'b0;
   logic [LW-1:0] dcache_req_data = '0;
   logic          dcache_rsp_valid;
   logic [LW-1:0] dcache_rsp_data;
   logic          mem_req_valid;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_is_store;
   logic [LW-1:0] mem_req_data;
   logic          mem_rsp_valid = 1'b0;
   logic [LW-1:0] mem_rsp_data = '0;
   logic          busy;
   logic          protocol_error;
   logic          timeout_error;

   mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
      .clock               (clock),
      .reset               (reset),
      .icache_req_valid    (icache_req_valid),
      .icache_req_addr     (icache_req_addr),
      .icache_rsp_valid    (icache_rsp_valid),
      .icache_rsp_data     (icache_rsp_data),
      .dcache_req_valid    (dcache_req_valid),
      .dcache_req_addr     (dcache_req_addr),
      .dcache_req_is_store (dcache_req_is_store),
      .dcache_req_data     (dcache_req_data),
      .dcache_rsp_valid    (dcache_rsp_valid),
      .dcache_rsp_data     (dcache_rsp_data),
      .mem_req_valid       (mem_req_valid),
      .mem_req_addr        (mem_req_addr),
      .mem_req_is_store    (mem_req_is_store),
      .mem_req_data        (mem_req_data),
      .mem_rsp_valid       (mem_rsp_valid),
      .mem_rsp_data        (mem_rsp_data),
      .busy                (busy),
      .protocol_error      (protocol_error),
      .timeout_error       (timeout_error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic          st;
      logic [LW-1:0] data;
   } mreq_t;

   typedef struct {
      int            cyc;
      logic          chk_data;
      logic [LW-1:0] data;
   } rsp_t;

   mreq_t mem_q[$];
   rsp_t  irsp_q[$];
   rsp_t  drsp_q[$];
   int    perr_q[$];
   int    terr_q[$];

   function automatic void chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void chk_int(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endfunction

   function automatic void unexp(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got unexpected pulse in cycle %0d, required none", nm, cyc);
   endfunction

   // monitor
   always @(negedge clock) begin
      mreq_t m;
      rsp_t  r;
      int    c;
      if (reset) begin
         if (mem_req_valid) begin
            if (mem_q.size() == 0) unexp("mem_req");
            else begin
               m = mem_q.pop_front();
               chk_int("mem_req cycle", cyc, m.cyc);
               chk("mem_req addr", LW'(mem_req_addr), LW'(m.addr));
               chk("mem_req is_store", LW'(mem_req_is_store), LW'(m.st));
               chk("mem_req data", mem_req_data, m.data);
            end
         end else begin
            chk("mem_req addr idle", LW'(mem_req_addr), '0);
            chk("mem_req data idle", mem_req_data, '0);
         end
         if (icache_rsp_valid) begin
            if (irsp_q.size() == 0) unexp("icache_rsp");
            else begin
               r = irsp_q.pop_front();
               chk_int("icache_rsp cycle", cyc, r.cyc);
               if (r.chk_data) chk("icache_rsp data", icache_rsp_data, r.data);
            end
         end else begin
            chk("icache_rsp data idle", icache_rsp_data, '0);
         end
         if (dcache_rsp_valid) begin
            if (drsp_q.size() == 0) unexp("dcache_rsp");
            else begin
               r = drsp_q.pop_front();
               chk_int("dcache_rsp cycle", cyc, r.cyc);
               if (r.chk_data) chk("dcache_rsp data", dcache_rsp_data, r.data);
            end
         end else begin
            chk("dcache_rsp data idle", dcache_rsp_data, '0);
         end
         if (protocol_error) begin
            if (perr_q.size() == 0) unexp("protocol_error");
            else begin
               c = perr_q.pop_front();
               chk_int("protocol_error cycle", cyc, c);
            end
         end
         if (timeout_error) begin
            if (terr_q.size() == 0) unexp("timeout_error");
            else begin
               c = terr_q.pop_front();
               chk_int("timeout_error cycle", cyc, c);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      icache_req_valid    = 1'b0;
      dcache_req_valid    = 1'b0;
      dcache_req_is_store = 1'b0;
      dcache_req_data     = '0;
      mem_rsp_valid       = 1'b0;
      mem_rsp_data        = '0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic push_mem(input int c, input logic [AW-1:0] a, input logic st,
                           input logic [LW-1:0] d);
      mreq_t m;
      m.cyc = c; m.addr = a; m.st = st; m.data = d;
      mem_q.push_back(m);
   endtask

   task automatic push_rsp(input logic is_d, input int c, input logic cd,
                           input logic [LW-1:0] d);
      rsp_t r;
      r.cyc = c; r.chk_data = cd; r.data = d;
      if (is_d) drsp_q.push_back(r);
      else      irsp_q.push_back(r);
   endtask

   task automatic ireq(input logic [AW-1:0] a);
      icache_req_valid = 1'b1;
      icache_req_addr  = a;
   endtask

   task automatic dreq(input logic [AW-1:0] a, input logic st, input logic [LW-1:0] d);
      dcache_req_valid    = 1'b1;
      dcache_req_addr     = a;
      dcache_req_is_store = st;
      dcache_req_data     = d;
   endtask

   task automatic mrsp(input logic [LW-1:0] d);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " busy"},             LW'(busy), '0);
      chk({tag, " mem_req_valid"},    LW'(mem_req_valid), '0);
      chk({tag, " mem_req_addr"},     LW'(mem_req_addr), '0);
      chk({tag, " mem_req_is_store"}, LW'(mem_req_is_store), '0);
      chk({tag, " mem_req_data"},     mem_req_data, '0);
      chk({tag, " icache_rsp_valid"}, LW'(icache_rsp_valid), '0);
      chk({tag, " icache_rsp_data"},  icache_rsp_data, '0);
      chk({tag, " dcache_rsp_valid"}, LW'(dcache_rsp_valid), '0);
      chk({tag, " dcache_rsp_data"},  dcache_rsp_data, '0);
      chk({tag, " protocol_error"},   LW'(protocol_error), '0);
      chk({tag, " timeout_error"},    LW'(timeout_error), '0);
   endtask

   localparam logic [LW-1:0] DA5  = {16{8'hA5}};
   localparam logic [LW-1:0] DBEE = {4{32'hDEAD_BEEF}};
   localparam logic [LW-1:0] D1   = {4{32'h1111_0001}};
   localparam logic [LW-1:0] D2   = {4{32'h2222_0002}};
   localparam logic [LW-1:0] D3   = {4{32'h3333_0003}};
   localparam logic [LW-1:0] D4   = {4{32'h4444_0004}};
   localparam logic [LW-1:0] D5   = {4{32'h5555_0005}};
   localparam logic [LW-1:0] D6   = {4{32'h6666_0006}};
   localparam logic [LW-1:0] D7   = {4{32'h7777_0007}};

   initial begin
      int c;
      ticks(2);
      check_all_zero("reset");
      reset = 1'b1;
      tick();

      // tie after reset: I$ first, D$ issued the cycle after I$ response
      c = cyc;
      ireq(32'h100);
      dreq(32'h200, 1'b0, '0);
      push_mem(c + 1, 32'h100, 1'b0, '0);
      tick();
      chk("tie1 busy in IDLE", LW'(busy), '0);
      tick();
      chk("tie1 busy in WAIT_RSP", LW'(busy), LW'(1));
      mrsp(D1);
      push_rsp(1'b0, c + 2, 1'b1, D1);
      push_mem(c + 3, 32'h200, 1'b0, '0);
      ticks(2);
      mrsp(D2);
      push_rsp(1'b1, c + 4, 1'b1, D2);
      ticks(2);

      // single I$ fill, response four cycles after the request
      c = cyc;
      ireq(32'h0000_1000);
      push_mem(c + 1, 32'h0000_1000, 1'b0, '0);
      ticks(5);
      mrsp(DA5);
      push_rsp(1'b0, c + 5, 1'b1, DA5);
      tick();
      chk("fill busy after rsp", LW'(busy), '0);
      tick();

      // tie with last_grant = I$: D$ first, then I$
      c = cyc;
      ireq(32'h140);
      dreq(32'h240, 1'b0, '0);
      push_mem(c + 1, 32'h240, 1'b0, '0);
      ticks(2);
      mrsp(D3);
      push_rsp(1'b1, c + 2, 1'b1, D3);
      push_mem(c + 3, 32'h140, 1'b0, '0);
      ticks(2);
      mrsp(D4);
      push_rsp(1'b0, c + 4, 1'b1, D4);
      ticks(2);

      // D$ eviction; next D$ fill arrives together with the ACK (reload)
      c = cyc;
      dreq(32'h3000, 1'b1, DBEE);
      push_mem(c + 1, 32'h3000, 1'b1, DBEE);
      ticks(2);
      mrsp('0);
      push_rsp(1'b1, c + 2, 1'b0, '0);
      dreq(32'h4000, 1'b0, '0);
      push_mem(c + 3, 32'h4000, 1'b0, '0);
      ticks(2);
      mrsp(D5);
      push_rsp(1'b1, c + 4, 1'b1, D5);
      ticks(2);

      // duplicate I$ request while pending: one error, one memory request
      c = cyc;
      ireq(32'h5000);
      push_mem(c + 1, 32'h5000, 1'b0, '0);
      tick();
      ireq(32'h6000);
      perr_q.push_back(c + 2);
      ticks(2);
      mrsp(D6);
      push_rsp(1'b0, c + 3, 1'b1, D6);
      ticks(4);

      // watchdog: no response for TO WAIT_RSP cycles, then reissue
      c = cyc;
      ireq(32'h7000);
      push_mem(c + 1, 32'h7000, 1'b0, '0);
      terr_q.push_back(c + 1 + TO);
      push_mem(c + 2 + TO, 32'h7000, 1'b0, '0);
      ticks(4 + TO);
      mrsp(D7);
      push_rsp(1'b0, c + 4 + TO, 1'b1, D7);
      ticks(2);

      // reset in WAIT_RSP, then a late response after release
      c = cyc;
      dreq(32'h8000, 1'b0, '0);
      push_mem(c + 1, 32'h8000, 1'b0, '0);
      ticks(2);
      chk("pre-reset busy", LW'(busy), LW'(1));
      reset = 1'b0;
      #1;
      check_all_zero("mid reset");
      ticks(2);
      reset = 1'b1;
      c = cyc;
      mrsp(D1);
      perr_q.push_back(c + 1);
      ticks(4);

      chk_int("mem_q drained",  mem_q.size(),  0);
      chk_int("irsp_q drained", irsp_q.size(), 0);
      chk_int("drsp_q drained", drsp_q.size(), 0);
      chk_int("perr_q drained", perr_q.size(), 0);
      chk_int("terr_q drained", terr_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
